proc_controller: RTL and testbench

PROC_CONTROLLER -- requirements
Module: proc_controller

---
 rtl/proc_controller_pkg.sv | 86 ++++++++
 rtl/proc_controller_if.sv | 27 ++
 rtl/proc_controller_prog_counter.sv | 25 ++
 rtl/proc_controller.sv | 107 ++++++++++
 tb/tb_proc_controller.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/proc_controller_pkg.sv
// Shared types and constants for the processor controller slice.
package proc_pkg;

   // Instruction opcodes carried in IR[15:12]; 4'hA..4'hF execute as NOOP.
   typedef enum logic [3:0] {
      OP_NOOP  = 4'h0,
      OP_STORE = 4'h1,
      OP_LOAD  = 4'h2,
      OP_ADD   = 4'h3,
      OP_SUB   = 4'h4,
      OP_HALT  = 4'h5,
      OP_XOR   = 4'h6,
      OP_OR    = 4'h7,
      OP_AND   = 4'h8,
      OP_INC   = 4'h9
   } opcode_t;

   // Controller states with fixed encodings, visible on the State debug port.
   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ALU_OP = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   // ALU operation selects, shared with the datapath ALU.
   typedef enum logic [2:0] {
      ALU_ZERO   = 3'b000,
      ALU_ADD    = 3'b001,
      ALU_SUB    = 3'b010,
      ALU_PASS_A = 3'b011,
      ALU_XOR    = 3'b100,
      ALU_OR     = 3'b101,
      ALU_AND    = 3'b110,
      ALU_INC    = 3'b111
   } alu_sel_t;

   // Instruction field positions.
   localparam int unsigned OP_MSB      = 15;
   localparam int unsigned OP_LSB      = 12;
   localparam int unsigned RA_MSB      = 11;
   localparam int unsigned RA_LSB      = 8;
   localparam int unsigned RB_MSB      = 7;
   localparam int unsigned RB_LSB      = 4;
   localparam int unsigned RQ_MSB      = 3;
   localparam int unsigned RQ_LSB      = 0;
   localparam int unsigned LD_ADDR_MSB = 11;
   localparam int unsigned LD_ADDR_LSB = 4;
   localparam int unsigned ST_ADDR_MSB = 7;
   localparam int unsigned ST_ADDR_LSB = 0;

   // Registered control outputs driven to the datapath.
   typedef struct packed {
      logic [7:0] d_addr;
      logic       d_wr;
      logic       rf_s;
      logic [3:0] rf_w_addr;
      logic       rf_w_en;
      logic [3:0] rf_ra_addr;
      logic [3:0] rf_rb_addr;
      logic [2:0] alu_sel;
      logic       halted;
   } ctrl_t;

   // Map an ALU-class opcode to its ALU select; anything else selects zero.
   function automatic logic [2:0] alu_sel_of(input logic [3:0] op);
      logic [2:0] sel;
      sel = ALU_ZERO;
      case (op)
         OP_ADD: sel = ALU_ADD;
         OP_SUB: sel = ALU_SUB;
         OP_XOR: sel = ALU_XOR;
         OP_OR:  sel = ALU_OR;
         OP_AND: sel = ALU_AND;
         OP_INC: sel = ALU_INC;
         default: sel = ALU_ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/proc_controller_if.sv
// Instruction memory, data memory and register-file control bus of the controller.
interface proc_controller_if;
   logic [15:0] IR_Data;
   logic [6:0]  PC_Addr;
   logic [7:0]  D_Addr;
   logic        D_Wr;
   logic        RF_s;
   logic [3:0]  RF_W_Addr;
   logic        RF_W_en;
   logic [3:0]  RF_Ra_Addr;
   logic [3:0]  RF_Rb_Addr;
   logic [2:0]  ALU_Sel;
   logic [3:0]  State;
   logic        Halted;

   modport master (
      input  IR_Data,
      output PC_Addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
             RF_Ra_Addr, RF_Rb_Addr, ALU_Sel, State, Halted
   );

   modport slave (
      output IR_Data,
      input  PC_Addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
             RF_Ra_Addr, RF_Rb_Addr, ALU_Sel, State, Halted
   );
endinterface

// File: rtl/proc_controller_prog_counter.sv
// 7-bit program counter with synchronous clear and increment enable; wraps 127 -> 0.
module prog_counter (
   input  logic       clk,
   input  logic       clr,
   input  logic       inc_en,
   output logic [6:0] count
);
   logic [6:0] count_q, count_d;

   // Next count: clear wins over increment.
   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (inc_en)
         count_d = count_q + 7'd1;
   end

   // Count register.
   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count = count_q;
endmodule

// File: rtl/proc_controller.sv
// Multi-cycle processor controller: fetch/decode/execute Moore FSM driving
// instruction memory, data memory and register-file controls.
module proc_controller
   import proc_pkg::*;
(
   input logic              Clk,
   input logic              ResetN,
   proc_controller_if.master bus
);
   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   ctrl_t       ctrl_q, ctrl_d;
   logic [6:0]  pc;

   prog_counter u_prog_counter (
      .clk    (Clk),
      .clr    (!ResetN),
      .inc_en (state_q == S_FETCH),
      .count  (pc)
   );

   // Next state and instruction register.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         S_INIT:   state_d = S_FETCH;
         S_FETCH: begin
            ir_d    = bus.IR_Data;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            case (ir_q[OP_MSB:OP_LSB])
               OP_STORE: state_d = S_STORE;
               OP_LOAD:  state_d = S_LOAD_A;
               OP_HALT:  state_d = S_HALT;
               OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_INC:
                         state_d = S_ALU_OP;
               default:  state_d = S_NOOP;
            endcase
         end
         S_LOAD_A: state_d = S_LOAD_B;
         S_LOAD_B, S_STORE, S_ALU_OP, S_NOOP:
                   state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_INIT;
      endcase
   end

   // Outputs are decoded from the next state/IR and registered, so the
   // registered outputs always match the current state and IR.
   always_comb begin
      ctrl_d = '0;
      case (state_d)
         S_LOAD_A: begin
            ctrl_d.d_addr = ir_d[LD_ADDR_MSB:LD_ADDR_LSB];
            ctrl_d.rf_s   = 1'b1;
         end
         S_LOAD_B: begin
            ctrl_d.d_addr    = ir_d[LD_ADDR_MSB:LD_ADDR_LSB];
            ctrl_d.rf_s      = 1'b1;
            ctrl_d.rf_w_addr = ir_d[RQ_MSB:RQ_LSB];
            ctrl_d.rf_w_en   = 1'b1;
         end
         S_STORE: begin
            ctrl_d.rf_ra_addr = ir_d[RA_MSB:RA_LSB];
            ctrl_d.d_addr     = ir_d[ST_ADDR_MSB:ST_ADDR_LSB];
            ctrl_d.d_wr       = 1'b1;
         end
         S_ALU_OP: begin
            ctrl_d.rf_ra_addr = ir_d[RA_MSB:RA_LSB];
            if (ir_d[OP_MSB:OP_LSB] != OP_INC)
               ctrl_d.rf_rb_addr = ir_d[RB_MSB:RB_LSB];
            ctrl_d.alu_sel   = alu_sel_of(ir_d[OP_MSB:OP_LSB]);
            ctrl_d.rf_w_addr = ir_d[RQ_MSB:RQ_LSB];
            ctrl_d.rf_w_en   = 1'b1;
         end
         S_HALT:   ctrl_d.halted = 1'b1;
         default:  ctrl_d = '0;
      endcase
   end

   // FSM state, instruction register and registered outputs.
   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         state_q <= S_INIT;
         ir_q    <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign bus.PC_Addr    = pc;
   assign bus.D_Addr     = ctrl_q.d_addr;
   assign bus.D_Wr       = ctrl_q.d_wr;
   assign bus.RF_s       = ctrl_q.rf_s;
   assign bus.RF_W_Addr  = ctrl_q.rf_w_addr;
   assign bus.RF_W_en    = ctrl_q.rf_w_en;
   assign bus.RF_Ra_Addr = ctrl_q.rf_ra_addr;
   assign bus.RF_Rb_Addr = ctrl_q.rf_rb_addr;
   assign bus.ALU_Sel    = ctrl_q.alu_sel;
   assign bus.State      = state_q;
   assign bus.Halted     = ctrl_q.halted;
endmodule

// File: tb/tb_proc_controller.sv
// Directed bench for proc_controller: reset, LOAD, ALU ops, STORE, NOOP/wrap,
// reset during LOAD and HALT.
module tb_proc_controller;
   import proc_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   logic [6:0] exp_pc;

   proc_controller_if bus();

   proc_controller dut (
      .Clk    (clk),
      .ResetN (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.IR_Data = 16'h0000;
      step(); step();
      checks++; if (bus.State !== 4'd0) begin errors++; $display("FAIL rst_state got=%0h exp=0", bus.State); end
      checks++; if (bus.PC_Addr !== 7'd0) begin errors++; $display("FAIL rst_pc got=%0h exp=0", bus.PC_Addr); end
      checks++; if (bus.D_Wr !== 1'b0 || bus.RF_W_en !== 1'b0) begin errors++; $display("FAIL rst_strobes got=%b%b exp=00", bus.D_Wr, bus.RF_W_en); end
      rst_n = 1'b1;
      checks++; if (bus.State !== 4'd0) begin errors++; $display("FAIL rst_init_hold got=%0h exp=0", bus.State); end
      step();
      checks++; if (bus.State !== 4'd1 || bus.PC_Addr !== 7'd0) begin errors++; $display("FAIL rst_first_fetch got=%0h/%0h exp=1/0", bus.State, bus.PC_Addr); end
      exp_pc = 7'd0;
   endtask

   task automatic test_load();
      bus.IR_Data = 16'h21B3;
      checks++; if (bus.State !== 4'd1) begin errors++; $display("FAIL ld_fetch got=%0h exp=1", bus.State); end
      step();
      exp_pc = exp_pc + 7'd1;
      checks++; if (bus.State !== 4'd2 || bus.PC_Addr !== exp_pc) begin errors++; $display("FAIL ld_decode got=%0h/%0h exp=2/%0h", bus.State, bus.PC_Addr, exp_pc); end
      step();
      checks++; if (bus.State !== 4'd4) begin errors++; $display("FAIL ld_a_state got=%0h exp=4", bus.State); end
      checks++; if (bus.D_Addr !== 8'h1B || bus.RF_s !== 1'b1 || bus.RF_W_en !== 1'b0) begin errors++; $display("FAIL ld_a_out got=%h/%b/%b exp=1b/1/0", bus.D_Addr, bus.RF_s, bus.RF_W_en); end
      step();
      checks++; if (bus.State !== 4'd5) begin errors++; $display("FAIL ld_b_state got=%0h exp=5", bus.State); end
      checks++; if (bus.RF_W_en !== 1'b1 || bus.RF_W_Addr !== 4'd3 || bus.RF_s !== 1'b1 || bus.D_Addr !== 8'h1B || bus.D_Wr !== 1'b0) begin errors++; $display("FAIL ld_b_out got=%b/%h/%b/%h/%b exp=1/3/1/1b/0", bus.RF_W_en, bus.RF_W_Addr, bus.RF_s, bus.D_Addr, bus.D_Wr); end
      step();
      checks++; if (bus.State !== 4'd1 || bus.RF_W_en !== 1'b0) begin errors++; $display("FAIL ld_refetch got=%0h/%b exp=1/0", bus.State, bus.RF_W_en); end
   endtask

   task automatic test_alu(input logic [15:0] ir, input logic [2:0] sel,
                           input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rq);
      bus.IR_Data = ir;
      step();
      exp_pc = exp_pc + 7'd1;
      checks++; if (bus.State !== 4'd2 || bus.PC_Addr !== exp_pc) begin errors++; $display("FAIL alu_decode ir=%h got=%0h/%0h exp=2/%0h", ir, bus.State, bus.PC_Addr, exp_pc); end
      step();
      checks++; if (bus.State !== 4'd7) begin errors++; $display("FAIL alu_state ir=%h got=%0h exp=7", ir, bus.State); end
      checks++; if (bus.RF_Ra_Addr !== ra || bus.RF_Rb_Addr !== rb || bus.ALU_Sel !== sel) begin errors++; $display("FAIL alu_operands ir=%h got=%h/%h/%b exp=%h/%h/%b", ir, bus.RF_Ra_Addr, bus.RF_Rb_Addr, bus.ALU_Sel, ra, rb, sel); end
      checks++; if (bus.RF_W_Addr !== rq || bus.RF_W_en !== 1'b1 || bus.RF_s !== 1'b0 || bus.D_Wr !== 1'b0) begin errors++; $display("FAIL alu_write ir=%h got=%h/%b/%b/%b exp=%h/1/0/0", ir, bus.RF_W_Addr, bus.RF_W_en, bus.RF_s, bus.D_Wr, rq); end
      step();
      checks++; if (bus.State !== 4'd1 || bus.RF_W_en !== 1'b0 || bus.ALU_Sel !== 3'b000) begin errors++; $display("FAIL alu_refetch ir=%h got=%0h/%b/%b exp=1/0/000", ir, bus.State, bus.RF_W_en, bus.ALU_Sel); end
   endtask

   task automatic test_store();
      bus.IR_Data = 16'h1460;
      step();
      exp_pc = exp_pc + 7'd1;
      step();
      checks++; if (bus.State !== 4'd6) begin errors++; $display("FAIL st_state got=%0h exp=6", bus.State); end
      checks++; if (bus.RF_Ra_Addr !== 4'd4 || bus.D_Addr !== 8'h60 || bus.D_Wr !== 1'b1 || bus.RF_W_en !== 1'b0) begin errors++; $display("FAIL st_out got=%h/%h/%b/%b exp=4/60/1/0", bus.RF_Ra_Addr, bus.D_Addr, bus.D_Wr, bus.RF_W_en); end
      step();
      checks++; if (bus.State !== 4'd1 || bus.D_Wr !== 1'b0 || bus.PC_Addr !== exp_pc) begin errors++; $display("FAIL st_one_cycle got=%0h/%b/%0h exp=1/0/%0h", bus.State, bus.D_Wr, bus.PC_Addr, exp_pc); end
   endtask

   task automatic test_noop_f000();
      bus.IR_Data = 16'hF000;
      step();
      exp_pc = exp_pc + 7'd1;
      step();
      checks++; if (bus.State !== 4'd3) begin errors++; $display("FAIL f000_state got=%0h exp=3", bus.State); end
      checks++; if (bus.D_Wr !== 1'b0 || bus.RF_W_en !== 1'b0 || bus.ALU_Sel !== 3'b000 || bus.RF_s !== 1'b0) begin errors++; $display("FAIL f000_strobes got=%b%b%b%b exp=000000", bus.D_Wr, bus.RF_W_en, bus.ALU_Sel, bus.RF_s); end
      step();
      checks++; if (bus.State !== 4'd1) begin errors++; $display("FAIL f000_refetch got=%0h exp=1", bus.State); end
   endtask

   task automatic test_pc_wrap();
      bus.IR_Data = 16'h0000;
      for (int i = 0; i < 128; i++) begin
         step();
         if (exp_pc == 7'd127) exp_pc = 7'd0;
         else exp_pc = exp_pc + 7'd1;
         checks++; if (bus.PC_Addr !== exp_pc) begin errors++; $display("FAIL wrap_pc i=%0d got=%0h exp=%0h", i, bus.PC_Addr, exp_pc); end
         step();
         checks++; if (bus.State !== 4'd3) begin errors++; $display("FAIL wrap_noop i=%0d got=%0h exp=3", i, bus.State); end
         step();
      end
   endtask

   task automatic test_reset_mid_load();
      bus.IR_Data = 16'h21B3;
      step(); step();
      checks++; if (bus.State !== 4'd4) begin errors++; $display("FAIL rml_load_a got=%0h exp=4", bus.State); end
      rst_n = 1'b0;
      step();
      checks++; if (bus.State !== 4'd0 || bus.PC_Addr !== 7'd0) begin errors++; $display("FAIL rml_init got=%0h/%0h exp=0/0", bus.State, bus.PC_Addr); end
      checks++; if (bus.RF_W_en !== 1'b0 || bus.RF_s !== 1'b0 || bus.D_Wr !== 1'b0) begin errors++; $display("FAIL rml_strobes got=%b%b%b exp=000", bus.RF_W_en, bus.RF_s, bus.D_Wr); end
      rst_n = 1'b1;
      step();
      checks++; if (bus.State !== 4'd1 || bus.RF_W_en !== 1'b0) begin errors++; $display("FAIL rml_fetch got=%0h/%b exp=1/0", bus.State, bus.RF_W_en); end
      exp_pc = 7'd0;
   endtask

   task automatic test_halt();
      bus.IR_Data = 16'h5000;
      step();
      exp_pc = exp_pc + 7'd1;
      step();
      bus.IR_Data = 16'h21B3;
      for (int i = 0; i < 20; i++) begin
         checks++; if (bus.State !== 4'd8 || bus.Halted !== 1'b1 || bus.PC_Addr !== exp_pc || bus.D_Wr !== 1'b0 || bus.RF_W_en !== 1'b0) begin errors++; $display("FAIL halt_hold i=%0d got=%0h/%b/%0h/%b/%b exp=8/1/%0h/0/0", i, bus.State, bus.Halted, bus.PC_Addr, bus.D_Wr, bus.RF_W_en, exp_pc); end
         step();
      end
      rst_n = 1'b0;
      step();
      checks++; if (bus.State !== 4'd0 || bus.Halted !== 1'b0 || bus.PC_Addr !== 7'd0) begin errors++; $display("FAIL halt_reset got=%0h/%b/%0h exp=0/0/0", bus.State, bus.Halted, bus.PC_Addr); end
      rst_n = 1'b1;
      step();
      checks++; if (bus.State !== 4'd1) begin errors++; $display("FAIL halt_refetch got=%0h exp=1", bus.State); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_alu(16'h3124, 3'b001, 4'd1, 4'd2, 4'd4);
      test_alu(16'h6124, 3'b100, 4'd1, 4'd2, 4'd4);
      test_alu(16'h9100, 3'b111, 4'd1, 4'd0, 4'd0);
      test_alu(16'h4A5C, 3'b010, 4'hA, 4'h5, 4'hC);
      test_store();
      test_noop_f000();
      test_pc_wrap();
      test_reset_mid_load();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
